shift_unit_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter for the ALU datapath.
- Supports four modes: logical left, logical right, arithmetic right and rotate right.
- One register stage per shift-amount bit. Shift amounts of WIDTH or more saturate.
- Valid/ready handshake on both sides so the execute stage can stall it.

---
 rtl/shift_unit_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_shift_unit_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR): one register stage per shift-amount bit, global-stall valid/ready.
// Define SHIFT_UNIT_CARRY_EN to add the out_carry port (last bit shifted out).
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
`ifdef SHIFT_UNIT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAST  = LOG2W - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             msb,
    input int               sh
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_SLL:  res = d << sh;
      OP_SRL:  res = d >> sh;
      OP_SRA:  res = ({WIDTH{msb}} & ~({WIDTH{1'b1}} >> sh)) | (d >> sh);
      default: res = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return res;
  endfunction

  logic r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic r_out_zero;
  logic w_adv;

  // Every stage moves together or the whole pipe freezes.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      localparam int AW = LOG2W - gi;

      logic             w_valid_in;
      logic [1:0]       w_op_in;
      logic [WIDTH-1:0] w_data_in;
      logic [AW-1:0]    w_amt_in;
      logic             w_sat_in;
      logic             w_msb_in;
      logic [WIDTH-1:0] w_data_sh;
`ifdef SHIFT_UNIT_CARRY_EN
      logic             w_carry_in;
      logic             w_exact_in;
      logic             w_carry_sh;
`endif

      if (gi == 0) begin : g_src
        assign w_valid_in = in_valid;
        assign w_op_in    = in_op;
        assign w_data_in  = in_data;
        assign w_amt_in   = in_amt[LOG2W-1:0];
        assign w_sat_in   = |in_amt[AMT_W-1:LOG2W];
        assign w_msb_in   = in_data[WIDTH-1];
`ifdef SHIFT_UNIT_CARRY_EN
        assign w_carry_in = 1'b0;
        // Amount exactly WIDTH: every original bit is gone and the last one out is an edge bit.
        assign w_exact_in = (in_amt >> LOG2W) == AMT_W'(1);
`endif
      end else begin : g_chain
        assign w_valid_in = g_stage[gi-1].g_reg.r_valid;
        assign w_op_in    = g_stage[gi-1].g_reg.r_op;
        assign w_data_in  = g_stage[gi-1].g_reg.r_data;
        assign w_amt_in   = g_stage[gi-1].g_reg.r_amt;
        assign w_sat_in   = g_stage[gi-1].g_reg.r_sat;
        assign w_msb_in   = g_stage[gi-1].g_reg.r_msb;
`ifdef SHIFT_UNIT_CARRY_EN
        assign w_carry_in = g_stage[gi-1].g_reg.r_carry;
        assign w_exact_in = g_stage[gi-1].g_reg.r_exact;
`endif
      end

      assign w_data_sh = w_amt_in[0] ? shift_step(w_data_in, w_op_in, w_msb_in, SH) : w_data_in;
`ifdef SHIFT_UNIT_CARRY_EN
      assign w_carry_sh = w_amt_in[0] ? ((w_op_in == OP_SLL) ? w_data_in[WIDTH-SH] : w_data_in[SH-1])
                                      : w_carry_in;
`endif

      // The last stage feeds the output register directly, so it has no stage register of its own.
      if (gi < LAST) begin : g_reg
        logic             r_valid;
        logic [1:0]       r_op;
        logic [WIDTH-1:0] r_data;
        logic [AW-2:0]    r_amt;
        logic             r_sat;
        logic             r_msb;
`ifdef SHIFT_UNIT_CARRY_EN
        logic             r_carry;
        logic             r_exact;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_data  <= '0;
            r_amt   <= '0;
            r_sat   <= 1'b0;
            r_msb   <= 1'b0;
`ifdef SHIFT_UNIT_CARRY_EN
            r_carry <= 1'b0;
            r_exact <= 1'b0;
`endif
          end else if (w_adv) begin
            r_valid <= w_valid_in;
            r_op    <= w_op_in;
            r_data  <= w_data_sh;
            r_amt   <= w_amt_in[AW-1:1];
            r_sat   <= w_sat_in;
            r_msb   <= w_msb_in;
`ifdef SHIFT_UNIT_CARRY_EN
            r_carry <= w_carry_sh;
            r_exact <= w_exact_in;
`endif
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] w_final_data;

  // Saturated amounts override the staged result; rotate only ever uses the amount modulo WIDTH.
  always_comb begin
    w_final_data = g_stage[LAST].w_data_sh;
    if (g_stage[LAST].w_sat_in && (g_stage[LAST].w_op_in != OP_ROR)) begin
      w_final_data = (g_stage[LAST].w_op_in == OP_SRA) ? {WIDTH{g_stage[LAST].w_msb_in}} : '0;
    end
  end

`ifdef SHIFT_UNIT_CARRY_EN
  logic w_final_carry;
  logic r_out_carry;

  always_comb begin
    w_final_carry = g_stage[LAST].w_carry_sh;
    if (g_stage[LAST].w_sat_in && (g_stage[LAST].w_op_in != OP_ROR)) begin
      if (g_stage[LAST].w_op_in == OP_SRA) begin
        w_final_carry = g_stage[LAST].w_msb_in;
      end else if (g_stage[LAST].w_exact_in) begin
        w_final_carry = (g_stage[LAST].w_op_in == OP_SLL) ? g_stage[LAST].w_data_in[0]
                                                          : g_stage[LAST].w_data_in[WIDTH-1];
      end else begin
        w_final_carry = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_carry <= 1'b0;
    end else if (w_adv) begin
      r_out_carry <= w_final_carry;
    end
  end

  assign out_carry = r_out_carry;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= g_stage[LAST].w_valid_in;
      r_out_data  <= w_final_data;
      r_out_zero  <= (w_final_data == '0);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe: an 8-bit and a 32-bit instance side by side.
module tb_shift_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, ordy8, oz8;
  logic [1:0] op8;
  logic [7:0] d8, q8, a8;
  logic        iv32, ir32, ov32, ordy32, oz32;
  logic [1:0]  op32;
  logic [31:0] d32, q32;
  logic [7:0]  a32;
`ifdef SHIFT_UNIT_CARRY_EN
  logic c8, c32;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit sel8 = 1'b0;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_zero;
  assign m_valid = sel8 ? ov8 : ov32;
  assign m_data  = sel8 ? {24'h0, q8} : q32;
  assign m_zero  = sel8 ? oz8 : oz32;
`ifdef SHIFT_UNIT_CARRY_EN
  logic m_carry;
  assign m_carry = sel8 ? c8 : c32;
`endif

  shift_unit_pipe #(.WIDTH(8), .AMT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_op(op8), .in_data(d8),
    .in_amt(a8), .out_valid(ov8), .out_ready(ordy8), .out_data(q8), .out_zero(oz8)
`ifdef SHIFT_UNIT_CARRY_EN
    , .out_carry(c8)
`endif
  );

  shift_unit_pipe #(.WIDTH(32), .AMT_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_op(op32), .in_data(d32),
    .in_amt(a32), .out_valid(ov32), .out_ready(ordy32), .out_data(q32), .out_zero(oz32)
`ifdef SHIFT_UNIT_CARRY_EN
    , .out_carry(c32)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation into an empty pipe and wait (bounded) for its result.
  task automatic run_op(input string tag, input bit w8, input logic [1:0] op, input logic [31:0] data,
                        input logic [7:0] amt, input logic [31:0] exp_d, input logic exp_z,
                        input logic exp_c);
    int edges;
    int lat;
    sel8 = w8;
    @(posedge clk); #1;
    if (w8) begin
      iv8 = 1'b1; op8 = op; d8 = data[7:0]; a8 = amt;
    end else begin
      iv32 = 1'b1; op32 = op; d32 = data; a32 = amt;
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    iv32 = 1'b0;
    edges = 1;
    lat = w8 ? 3 : 5;
    while (!m_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "/latency"}, edges, lat);
    check({tag, "/data"}, m_data, exp_d);
    check({tag, "/zero"}, m_zero, exp_z);
`ifdef SHIFT_UNIT_CARRY_EN
    check({tag, "/carry"}, m_carry, exp_c);
`else
    if (exp_c === 1'bx) $display("note %s: carry expectation undefined", tag);
`endif
    $display("txn %s op=%0d data=%h amt=%0d -> out=%h zero=%b latency=%0d",
             tag, op, data, amt, m_data, m_zero, edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] held;
    int sent;
    int got;
    int stray;

    iv8 = 0; op8 = 0; d8 = 0; a8 = 0; ordy8 = 1;
    iv32 = 0; op32 = 0; d32 = 0; a32 = 0; ordy32 = 1;
    held = 0;

    #2;
    check("rst/ov8", ov8, 0);
    check("rst/q8", q8, 0);
    check("rst/oz8", oz8, 0);
    check("rst/ov32", ov32, 0);
    check("rst/q32", q32, 0);
    check("rst/oz32", oz32, 0);
`ifdef SHIFT_UNIT_CARRY_EN
    check("rst/c32", c32, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst/ir8", ir8, 1);
    check("rst/ir32", ir32, 1);

    run_op("sra8",      1'b1, 2'd2, 32'h0000_00B2, 8'd3,   32'h0000_00F6, 1'b0, 1'b0);
    run_op("sll8",      1'b1, 2'd0, 32'h0000_0081, 8'd1,   32'h0000_0002, 1'b0, 1'b1);
    run_op("ror8_by8",  1'b1, 2'd3, 32'h0000_00A5, 8'd8,   32'h0000_00A5, 1'b0, 1'b0);
    run_op("srl8_sat",  1'b1, 2'd1, 32'h0000_00FF, 8'd9,   32'h0000_0000, 1'b1, 1'b0);

    run_op("sll31",     1'b0, 2'd0, 32'h0000_0001, 8'd31,  32'h8000_0000, 1'b0, 1'b0);
    run_op("srl40",     1'b0, 2'd1, 32'h8000_0000, 8'd40,  32'h0000_0000, 1'b1, 1'b0);
    run_op("sra200",    1'b0, 2'd2, 32'h8000_0000, 8'd200, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("ror36",     1'b0, 2'd3, 32'h1234_5678, 8'd36,  32'h8123_4567, 1'b0, 1'b1);
    run_op("sra0",      1'b0, 2'd2, 32'h8000_0000, 8'd0,   32'h8000_0000, 1'b0, 1'b0);
    run_op("ror64",     1'b0, 2'd3, 32'h1234_5678, 8'd64,  32'h1234_5678, 1'b0, 1'b0);
    run_op("sll32",     1'b0, 2'd0, 32'h0000_0001, 8'd32,  32'h0000_0000, 1'b1, 1'b1);
    run_op("srl32",     1'b0, 2'd1, 32'h8000_0000, 8'd32,  32'h0000_0000, 1'b1, 1'b1);
    run_op("srl4",      1'b0, 2'd1, 32'h0000_0018, 8'd4,   32'h0000_0001, 1'b0, 1'b1);
    run_op("sra28",     1'b0, 2'd2, 32'h7000_0000, 8'd28,  32'h0000_0007, 1'b0, 1'b0);

    // Back-to-back: op c is set after edge c, accepted on edge c+1, visible after edge c+5.
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        iv32 = 1'b1; op32 = 2'd0; d32 = 32'h0000_0001; a32 = 8'(c);
      end else begin
        iv32 = 1'b0;
      end
      check("b2b/valid", ov32, (c >= 5 && c < 13));
      if (c >= 5 && c < 13) begin
        check("b2b/data", q32, 32'h0000_0001 << (c - 5));
        $display("txn b2b #%0d out=%h", c - 5, q32);
      end
    end
    iv32 = 1'b0;

    // Stall: consumer refuses for 4 cycles while the pipe is full.
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(posedge clk); #1;
      ordy32 = !(c >= 8 && c < 12);
      #1;
      if (c >= 8 && c < 12) begin
        check("stall/in_ready", ir32, 0);
        check("stall/valid", ov32, 1);
        if (c == 8) held = q32;
        else check("stall/hold", q32, held);
      end
      if (ov32 && ordy32) begin
        if (exp_q.size() == 0) begin
          check("stall/extra", ov32, 0);
        end else begin
          check("stall/data", q32, exp_q.pop_front());
          $display("txn stall #%0d out=%h", got, q32);
          got++;
        end
      end
      if (sent < 10) begin
        iv32 = 1'b1; op32 = 2'd1; d32 = 32'h8000_0000; a32 = 8'(sent);
        if (ir32) begin
          exp_q.push_back(32'h8000_0000 >> sent);
          sent++;
        end
      end else begin
        iv32 = 1'b0;
      end
    end
    iv32 = 1'b0;
    ordy32 = 1'b1;
    check("stall/count", got, 10);
    check("stall/left", exp_q.size(), 0);

    // Reset with three operations in flight, the oldest already at the output.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin
        iv32 = 1'b1; op32 = 2'd0; d32 = 32'h0000_0003; a32 = 8'(c + 1);
      end else begin
        iv32 = 1'b0;
      end
    end
    check("rstmid/pre_valid", ov32, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid/valid", ov32, 0);
    check("rstmid/data", q32, 0);
    check("rstmid/zero", oz32, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov32) stray++;
    end
    check("rstmid/stray", stray, 0);
    run_op("rstmid/after", 1'b0, 2'd2, 32'h7000_0000, 8'd28, 32'h0000_0007, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
